// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle add/subtract unit. A SIZE-bit operation is split into
//   NCHUNK = SIZE/CHUNK slices, and one slice is added per clock. The carry
//   between slices is held in a register, so the combinational carry path is
//   only CHUNK bits long. Operations are requested with a start/done handshake.
//
// Parameters
//   SIZE    operand/result width in bits
//   CHUNK   bits added per cycle (SIZE % CHUNK == 0, 1 <= CHUNK <= SIZE)
//
// Ports
//   clk_i    in   1     clock, rising edge
//   rst_i    in   1     synchronous active-high reset
//   start_i  in   1     operation request, sampled only while idle
//   sub_i    in   1     0: dinx_i + diny_i, 1: dinx_i - diny_i
//   dinx_i   in   SIZE  operand x
//   diny_i   in   SIZE  operand y
//   busy_o   out  1     high while an operation is running or completing
//   done_o   out  1     one-cycle pulse, result outputs valid
//   sum_o    out  SIZE  result (registered, updated only on completion)
//   cout_o   out  1     carry out of the MSB (for subtract, 1 = no borrow)
//   ovf_o    out  1     two's-complement signed overflow
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            sub_i,
  input  logic [SIZE-1:0] dinx_i,
  input  logic [SIZE-1:0] diny_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [SIZE-1:0] sum_o,
  output logic            cout_o,
  output logic            ovf_o
);

  localparam int NCHUNK = SIZE / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SIZE-1:0]  xr;
  logic [SIZE-1:0]  yr;
  logic [SIZE-1:0]  acc;
  logic [SIZE-1:0]  acc_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK:0]   chunk_res;
  logic             last_chunk;
  int               chunk_base;

  // One slice of the ripple: CHUNK-bit add with carry in, CHUNK+1 bit result.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Signed overflow: operands of equal sign producing a result of the other sign.
  // yr already holds ~y for subtraction, so this covers both operations.
  function automatic logic signed_ovf(input logic x_msb,
                                      input logic y_msb,
                                      input logic r_msb);
    return (x_msb == y_msb) && (r_msb != x_msb);
  endfunction

  assign last_chunk = (idx == LAST_IDX);
  assign chunk_base = int'(idx) * CHUNK;

  // Slice currently addressed by idx, merged into the accumulator.
  always_comb begin
    chunk_res = chunk_add(xr[chunk_base +: CHUNK], yr[chunk_base +: CHUNK], carry);
    acc_nxt   = acc;
    acc_nxt[chunk_base +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start_i)    state_nxt = ST_RUN;
      ST_RUN:  if (last_chunk) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state != ST_IDLE);
    done_o = (state == ST_DONE);
  end

  // Datapath: operand capture on accept, one slice per RUN cycle, result
  // registers touched only on the edge that finishes the last slice.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xr     <= '0;
      yr     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_o  <= '0;
      cout_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            // Subtraction is x + ~y + 1: invert y and seed the carry with 1.
            xr    <= dinx_i;
            yr    <= sub_i ? ~diny_i : diny_i;
            carry <= sub_i;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_nxt;
          carry <= chunk_res[CHUNK];
          idx   <= idx + 1'b1;
          if (last_chunk) begin
            sum_o  <= acc_nxt;
            cout_o <= chunk_res[CHUNK];
            ovf_o  <= signed_ovf(xr[SIZE-1], yr[SIZE-1], acc_nxt[SIZE-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Bench for seq_chunk_adder with three instances: SIZE=16/CHUNK=4,
//   SIZE=4/CHUNK=2 and SIZE=8/CHUNK=8 (single-chunk case). Operand and
//   sub inputs are shared; each instance has its own start. Results are
//   compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, start4, start8;
  logic        sub;
  logic [15:0] dinx, diny;

  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int errors = 0;
  int checks = 0;

  seq_chunk_adder #(.SIZE(16), .CHUNK(4)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .sub_i(sub),
    .dinx_i(dinx), .diny_i(diny),
    .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  seq_chunk_adder #(.SIZE(4), .CHUNK(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .sub_i(sub),
    .dinx_i(dinx[3:0]), .diny_i(diny[3:0]),
    .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4), .ovf_o(ovf4)
  );

  seq_chunk_adder #(.SIZE(8), .CHUNK(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub),
    .dinx_i(dinx[7:0]), .diny_i(diny[7:0]),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          w;
    logic [15:0] x;
    logic [15:0] y;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int size, input logic [15:0] x, input logic [15:0] y,
                                input logic sb, output logic [15:0] s,
                                output logic c, output logic v);
    longint m, xs, ys, full, half, sx, sy, r;
    m    = longint'(1) << size;
    half = m / 2;
    xs   = longint'(x) % m;
    ys   = longint'(y) % m;
    if (!sb) begin
      full = xs + ys;
      s    = 16'(full % m);
      c    = (full >= m);
    end else begin
      s    = 16'((xs - ys + m) % m);
      c    = (xs >= ys);
    end
    sx = (xs >= half) ? xs - m : xs;
    sy = (ys >= half) ? ys - m : ys;
    r  = sb ? (sx - sy) : (sx + sy);
    v  = (r >= half) || (r < -half);
  endfunction

  function automatic int nchunk(input int w);
    case (w)
      4:       return 2;
      8:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_out(input int w, output logic b, output logic d,
                         output logic [15:0] s, output logic c, output logic v);
    case (w)
      4:       begin b = busy4;  d = done4;  s = {12'h0, sum4}; c = cout4;  v = ovf4;  end
      8:       begin b = busy8;  d = done8;  s = {8'h0, sum8};  c = cout8;  v = ovf8;  end
      default: begin b = busy16; d = done16; s = sum16;         c = cout16; v = ovf16; end
    endcase
  endtask

  task automatic set_start(input int w, input logic val);
    case (w)
      4:       start4  = val;
      8:       start8  = val;
      default: start16 = val;
    endcase
  endtask

  // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
  // Inputs are scrambled right after the accept edge.
  task automatic do_op(input int w, input logic [15:0] x, input logic [15:0] y,
                       input logic sb, output int lat);
    logic b, d, c, v;
    logic [15:0] s;
    dinx = x; diny = y; sub = sb;
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    dinx = 16'($urandom); diny = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    get_out(w, b, d, s, c, v);
    while (!d && lat < 50) begin
      tick();
      lat++;
      get_out(w, b, d, s, c, v);
    end
    if (!d) lat = -1;
  endtask

  task automatic test_reset();
    logic b, d, c, v;
    logic [15:0] s;
    int ws[3] = '{16, 4, 8};
    rst = 1'b1; start16 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    sub = 1'b0; dinx = 16'hFFFF; diny = 16'hFFFF;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      get_out(ws[i], b, d, s, c, v);
      checks++;
      if ({b, d, s, c, v} !== 20'h0) begin
        errors++;
        $display("FAIL reset_w%0d: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
                 ws[i], b, d, s, c, v);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    logic b, d, c, v;
    logic [15:0] s;
    int lat;
    vecs[0] = '{4,  16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{8,  16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
    vecs[5] = '{8,  16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].w, vecs[i].x, vecs[i].y, vecs[i].sb, lat);
      get_out(vecs[i].w, b, d, s, c, v);
      checks++;
      if (lat !== nchunk(vecs[i].w)) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d cycles, need %0d", i, lat, nchunk(vecs[i].w));
      end
      checks++;
      if ({s, c, v} !== {vecs[i].s, vecs[i].c, vecs[i].v}) begin
        errors++;
        $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                 i, s, c, v, vecs[i].s, vecs[i].c, vecs[i].v);
      end
      tick();
      tick();
      get_out(vecs[i].w, b, d, s, c, v);
      checks++;
      if ({b, d, s, c, v} !== {2'b00, vecs[i].s, vecs[i].c, vecs[i].v}) begin
        errors++;
        $display("FAIL dir%0d_hold_idle: got busy=%b done=%b sum=%h cout=%b ovf=%b, need idle holding sum=%h",
                 i, b, d, s, c, v, vecs[i].s);
      end
    end
  endtask

  // Result outputs must not move on accept or during RUN.
  task automatic test_hold();
    logic [15:0] prev;
    int changed;
    prev = sum16;
    changed = 0;
    dinx = 16'h0101; diny = 16'h0202; sub = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({sum16, cout16, ovf16} !== {prev, 2'b10}) changed++;
      if (i < 3) tick();
    end
    checks++;
    if (changed != 0) begin
      errors++;
      $display("FAIL hold_during_run: outputs moved in %0d of 4 cycles, need 0 (prev sum=%h)", changed, prev);
    end
    tick();
    checks++;
    if ({done16, sum16} !== {1'b1, 16'h0303}) begin
      errors++;
      $display("FAIL hold_completion: got done=%b sum=%h, need done=1 sum=0303", done16, sum16);
    end
    tick();
  endtask

  task automatic test_busy();
    int nb, nd;
    logic [15:0] sd;
    nb = 0; nd = 0; sd = 16'hxxxx;
    dinx = 16'h1234; diny = 16'h1111; sub = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy16) nb++;
      if (done16) begin nd++; sd = sum16; end
      if (i == 1) begin start16 = 1'b1; dinx = 16'hFFFF; end
      else        start16 = 1'b0;
      tick();
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d done pulses, need 1", nd);
    end
    checks++;
    if (sd !== 16'h2345) begin
      errors++;
      $display("FAIL busy_sum: got %h, need 2345", sd);
    end
    checks++;
    if (nb != 5) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, need 5", nb);
    end
    checks++;
    if (busy16 !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: got busy=%b, need 0", busy16);
    end
  endtask

  task automatic test_reset_mid();
    int nd, lat;
    dinx = 16'h1234; diny = 16'h4321; sub = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done16) nd++;
    end
    checks++;
    if (nd != 0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got %0d done pulses busy=%b, need 0 and 0", nd, busy16);
    end
    do_op(16, 16'h00FF, 16'h0001, 1'b0, lat);
    checks++;
    if (lat != 4 || sum16 !== 16'h0100) begin
      errors++;
      $display("FAIL reset_fresh_op: got latency=%0d sum=%h, need 4 and 0100", lat, sum16);
    end
    tick();
  endtask

  task automatic test_random_small();
    int ws[2] = '{4, 8};
    logic b, d, c, v, ec, ev;
    logic [15:0] s, es, x, y;
    logic sb;
    int lat;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        x = 16'($urandom); y = 16'($urandom); sb = 1'($urandom);
        do_op(ws[k], x, y, sb, lat);
        get_out(ws[k], b, d, s, c, v);
        model(ws[k], x, y, sb, es, ec, ev);
        checks++;
        if (lat != nchunk(ws[k]) || {s, c, v} !== {es, ec, ev}) begin
          errors++;
          $display("FAIL rand_w%0d x=%h y=%h sub=%b: got lat=%0d sum=%h cout=%b ovf=%b, need lat=%0d sum=%h cout=%b ovf=%b",
                   ws[k], x, y, sb, lat, s, c, v, nchunk(ws[k]), es, ec, ev);
        end
        tick();
      end
    end
  endtask

  // start_i held high: accepts land every NCHUNK+2 = 6 cycles.
  task automatic test_back_to_back();
    logic [15:0] qx[$], qy[$];
    logic        qs[$];
    logic [15:0] x, y, es;
    logic sb, ec, ev;
    int guard, ph;
    guard = 0;
    while (busy16 && guard < 20) begin tick(); guard++; end
    checks++;
    if (busy16) begin
      errors++;
      $display("FAIL stream_idle_wait: busy=%b after %0d cycles, need 0", busy16, guard);
    end
    start16 = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      ph = cyc % 6;
      dinx = 16'($urandom); diny = 16'($urandom); sub = 1'($urandom);
      if (ph == 0) begin qx.push_back(dinx); qy.push_back(diny); qs.push_back(sub); end
      tick();
      checks++;
      if (done16 !== (ph == 4) || busy16 !== (ph != 5)) begin
        errors++;
        $display("FAIL stream_cycle%0d: got done=%b busy=%b, need done=%b busy=%b",
                 cyc, done16, busy16, (ph == 4), (ph != 5));
      end
      if (ph == 4 && qx.size() > 0) begin
        x = qx.pop_front(); y = qy.pop_front(); sb = qs.pop_front();
        model(16, x, y, sb, es, ec, ev);
        checks++;
        if ({sum16, cout16, ovf16} !== {es, ec, ev}) begin
          errors++;
          $display("FAIL stream_op%0d x=%h y=%h sub=%b: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                   cyc / 6, x, y, sb, sum16, cout16, ovf16, es, ec, ev);
        end
      end
    end
    start16 = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_busy();
    test_reset_mid();
    test_random_small();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
